carbon_core_p: RTL and testbench

- Parametrised, single-clock successor to the two-phase 8-bit accumulator core.
- Data width, PC width and return-stack depth are parameters.
- A FETCH/EXEC state machine with a ready/valid instruction-fetch handshake replaces the clkA/clkB split, so instruction memory may insert wait states.
- Adds CALL/RET with a bounded hardware return stack, a registered output-strobe, and HALT. Sits between instruction ROM, input port and output port at system top.

---
 rtl/carbon_core_p_if.sv | 25 ++
 rtl/carbon_core_p.sv | 204 ++++++++++++++++++++
 tb/tb_carbon_core_p.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/carbon_core_p_if.sv
// Bus bundle between carbon_core_p (master) and its instruction ROM / input / output ports (slave).
interface carbon_core_p_if #(
    parameter int DW = 8,
    parameter int AW = 8
) ();
    logic [AW-1:0] pc_o;
    logic          inst_req;
    logic          inst_valid;
    logic [DW+5:0] inst;
    logic [DW-1:0] di;
    logic [DW-1:0] do_o;
    logic          do_we;
    logic          halted;
    logic          stk_err;

    modport master (
        output pc_o, inst_req, do_o, do_we, halted, stk_err,
        input  inst_valid, inst, di
    );

    modport slave (
        input  pc_o, inst_req, do_o, do_we, halted, stk_err,
        output inst_valid, inst, di
    );
endinterface

// File: rtl/carbon_core_p.sv
// Single-clock accumulator core: FETCH/EXEC sequencer, bounded return stack, OUT strobe, HALT.
// Optional carry flag with ADCI/JC is enabled by defining CARBON_CORE_CARRY_EN.
module carbon_core_p #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int STK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    carbon_core_p_if.master bus
);
    localparam int SPW   = $clog2(STK_DEPTH + 1);
    localparam int STK_N = 1 << SPW;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HLT   = 2'd2;

    localparam logic [5:0] OP_LDI   = 6'h01;
    localparam logic [5:0] OP_ADDI  = 6'h02;
    localparam logic [5:0] OP_SUBI  = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h06;
    localparam logic [5:0] OP_IN    = 6'h07;
    localparam logic [5:0] OP_ADDIN = 6'h08;
    localparam logic [5:0] OP_OUT   = 6'h09;
    localparam logic [5:0] OP_ADCI  = 6'h0A;
    localparam logic [5:0] OP_JMP   = 6'h10;
    localparam logic [5:0] OP_JZ    = 6'h11;
    localparam logic [5:0] OP_JNZ   = 6'h12;
    localparam logic [5:0] OP_CALL  = 6'h13;
    localparam logic [5:0] OP_RET   = 6'h14;
    localparam logic [5:0] OP_JC    = 6'h15;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    logic [1:0]     state;
    logic [AW-1:0]  pc;
    logic [DW-1:0]  acc;
    logic [DW+5:0]  ir;
    logic [SPW-1:0] sp;
    logic [AW-1:0]  stk [STK_N];
    logic [DW-1:0]  do_r;
    logic           do_we_r;
    logic           halted_r;
    logic           stk_err_r;

`ifdef CARBON_CORE_CARRY_EN
    logic cy;
    logic cy_nx;

    function automatic logic [DW:0] add_c(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic cin);
        return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    endfunction

    // Bit DW of the extended difference is the borrow.
    function automatic logic [DW:0] sub_b(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction
`endif

    logic [5:0]     op;
    logic [DW-1:0]  c;
    logic [AW-1:0]  pc_inc;
    logic [AW-1:0]  tgt;
    logic [SPW-1:0] sp_dec;
    logic           stk_full;
    logic           stk_empty;

    assign op        = ir[DW+5:DW];
    assign c         = ir[DW-1:0];
    assign pc_inc    = pc + AW'(1);
    assign tgt       = c[AW-1:0];
    assign sp_dec    = sp - SPW'(1);
    assign stk_full  = (sp == SPW'(STK_DEPTH));
    assign stk_empty = (sp == '0);

    logic [DW-1:0] acc_nx;
    logic [AW-1:0] pc_nx;
    logic          push;
    logic          pop;
    logic          err_set;
    logic          out_en;
    logic          halt;

    always_comb begin
        acc_nx  = acc;
        pc_nx   = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        out_en  = 1'b0;
        halt    = 1'b0;
`ifdef CARBON_CORE_CARRY_EN
        cy_nx   = cy;
`endif
        case (op)
            OP_LDI:   acc_nx = c;
`ifdef CARBON_CORE_CARRY_EN
            OP_ADDI:  {cy_nx, acc_nx} = add_c(acc, c, 1'b0);
            OP_SUBI:  {cy_nx, acc_nx} = sub_b(acc, c);
            OP_ADDIN: {cy_nx, acc_nx} = add_c(acc, bus.di, 1'b0);
            OP_ADCI:  {cy_nx, acc_nx} = add_c(acc, c, cy);
            OP_ANDI:  begin acc_nx = acc & c; cy_nx = 1'b0; end
            OP_ORI:   begin acc_nx = acc | c; cy_nx = 1'b0; end
            OP_XORI:  begin acc_nx = acc ^ c; cy_nx = 1'b0; end
            OP_JC:    if (cy) pc_nx = tgt;
`else
            OP_ADDI:  acc_nx = acc + c;
            OP_SUBI:  acc_nx = acc - c;
            OP_ADDIN: acc_nx = acc + bus.di;
            OP_ANDI:  acc_nx = acc & c;
            OP_ORI:   acc_nx = acc | c;
            OP_XORI:  acc_nx = acc ^ c;
`endif
            OP_IN:    acc_nx = bus.di;
            OP_OUT:   out_en = 1'b1;
            OP_JMP:   pc_nx = tgt;
            OP_JZ:    if (acc == '0) pc_nx = tgt;
            OP_JNZ:   if (acc != '0) pc_nx = tgt;
            OP_CALL: begin
                // A full stack drops the call and falls through with the error flagged.
                if (stk_full) begin
                    err_set = 1'b1;
                end else begin
                    push  = 1'b1;
                    pc_nx = tgt;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    err_set = 1'b1;
                end else begin
                    pop   = 1'b1;
                    pc_nx = stk[sp_dec];
                end
            end
            OP_HALT:  halt = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= '0;
            acc       <= '0;
            ir        <= '0;
            sp        <= '0;
            do_r      <= '0;
            do_we_r   <= 1'b0;
            halted_r  <= 1'b0;
            stk_err_r <= 1'b0;
`ifdef CARBON_CORE_CARRY_EN
            cy        <= 1'b0;
`endif
        end else begin
            do_we_r <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (bus.inst_valid) begin
                        ir    <= bus.inst;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (halt) begin
                        halted_r <= 1'b1;
                        state    <= S_HLT;
                    end else begin
                        acc   <= acc_nx;
                        pc    <= pc_nx;
                        state <= S_FETCH;
                        if (push) sp <= sp + SPW'(1);
                        if (pop)  sp <= sp_dec;
                        if (err_set) stk_err_r <= 1'b1;
                        if (out_en) begin
                            do_r    <= acc;
                            do_we_r <= 1'b1;
                        end
`ifdef CARBON_CORE_CARRY_EN
                        cy <= cy_nx;
`endif
                    end
                end
                S_HLT:   ;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Stack contents are data only; the stack pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && state == S_EXEC && push) stk[sp] <= pc_inc;
    end

    assign bus.pc_o     = pc;
    assign bus.inst_req = (state == S_FETCH);
    assign bus.do_o     = do_r;
    assign bus.do_we    = do_we_r;
    assign bus.halted   = halted_r;
    assign bus.stk_err  = stk_err_r;
endmodule

// File: tb/tb_carbon_core_p.sv
// Scoreboard bench for carbon_core_p: expected fetches and OUT values are queued per program
// and popped by an independent monitor whenever the core fetches or strobes do_we.
module tb_carbon_core_p;
    localparam int DW        = 8;
    localparam int AW        = 8;
    localparam int STK_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    carbon_core_p_if #(.DW(DW), .AW(AW)) bus ();

    carbon_core_p #(.DW(DW), .AW(AW), .STK_DEPTH(STK_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [13:0] rom [256];
    logic        mem_en;
    logic [7:0]  di_val;
    logic        chk_fetch;
    logic        prev_we;
    logic [8:0]  fetch_q [$];
    logic [7:0]  out_q [$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [13:0] ins(input logic [5:0] op, input logic [7:0] c);
        return {op, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_fetch(input logic [7:0] pc, input logic err);
        fetch_q.push_back({err, pc});
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = ins(6'h3F, 8'h00);
    endtask

    // Instruction memory / input port model, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        bus.inst_valid = mem_en && bus.inst_req;
        bus.inst       = rom[bus.pc_o];
        bus.di         = di_val;
    end

    // Monitor: pops the scoreboards on fetch handshakes and output strobes.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (chk_fetch && bus.inst_req && bus.inst_valid) begin
                if (fetch_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fetch_extra: got pc %0h expected no fetch", bus.pc_o);
                end else begin
                    logic [8:0] e;
                    e = fetch_q.pop_front();
                    check("fetch_pc", 32'(bus.pc_o), 32'(e[7:0]));
                    check("fetch_stk_err", 32'(bus.stk_err), 32'(e[8]));
                end
            end
            if (bus.do_we) begin
                check("do_we_single", 32'(prev_we), 32'd0);
                if (out_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_extra: got do_o %0h expected no strobe", bus.do_o);
                end else begin
                    logic [7:0] o;
                    o = out_q.pop_front();
                    check("do_o", 32'(bus.do_o), 32'(o));
                end
            end
        end
        prev_we = bus.do_we;
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, 32'(bus.pc_o), 32'd0);
        check({tag, "_req"}, 32'(bus.inst_req), 32'd1);
        check({tag, "_do_o"}, 32'(bus.do_o), 32'd0);
        check({tag, "_do_we"}, 32'(bus.do_we), 32'd0);
        check({tag, "_halted"}, 32'(bus.halted), 32'd0);
        check({tag, "_stk_err"}, 32'(bus.stk_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        mem_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input logic [7:0] hpc);
        int n;
        n = 0;
        mem_en = 1'b1;
        while (bus.halted !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", 32'(bus.halted), 32'd1);
        repeat (10) begin
            @(negedge clk);
            check("halt_flag", 32'(bus.halted), 32'd1);
            check("halt_req", 32'(bus.inst_req), 32'd0);
            check("halt_pc", 32'(bus.pc_o), 32'(hpc));
        end
        check("fetch_left", 32'(fetch_q.size()), 32'd0);
        check("out_left", 32'(out_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_en    = 1'b0;
        di_val    = 8'h33;
        chk_fetch = 1'b1;
        prev_we   = 1'b0;

        // Reset, fetch wait states, arithmetic wrap, logic ops, IN/ADDIN, unknown opcode.
        clear_rom();
        rom[8'h00] = ins(6'h01, 8'h5A);
        rom[8'h01] = ins(6'h09, 8'h00);
        rom[8'h02] = ins(6'h01, 8'hF0);
        rom[8'h03] = ins(6'h02, 8'h20);
        rom[8'h04] = ins(6'h09, 8'h00);
        rom[8'h05] = ins(6'h03, 8'h11);
        rom[8'h06] = ins(6'h09, 8'h00);
        rom[8'h07] = ins(6'h04, 8'h0F);
        rom[8'h08] = ins(6'h05, 8'h30);
        rom[8'h09] = ins(6'h06, 8'hFF);
        rom[8'h0A] = ins(6'h09, 8'h00);
        rom[8'h0B] = ins(6'h07, 8'h00);
        rom[8'h0C] = ins(6'h09, 8'h00);
        rom[8'h0D] = ins(6'h08, 8'h00);
        rom[8'h0E] = ins(6'h09, 8'h00);
        rom[8'h0F] = ins(6'h20, 8'hFF);
        rom[8'h10] = ins(6'h09, 8'h00);
        for (int i = 0; i <= 8'h11; i++) push_fetch(8'(i), 1'b0);
        out_q = '{8'h5A, 8'h10, 8'hFF, 8'hC0, 8'h33, 8'h66, 8'h66};
        do_reset();
        repeat (3) begin
            @(negedge clk);
            check("wait_pc", 32'(bus.pc_o), 32'd0);
            check("wait_req", 32'(bus.inst_req), 32'd1);
        end
        run_to_halt(8'h11);

        // Conditional branches and PC wrap from 0xFF.
        clear_rom();
        rom[8'h00] = ins(6'h11, 8'h10);
        rom[8'h10] = ins(6'h01, 8'h00);
        rom[8'h11] = ins(6'h11, 8'h40);
        rom[8'h40] = ins(6'h01, 8'h01);
        rom[8'h41] = ins(6'h11, 8'h80);
        rom[8'h42] = ins(6'h12, 8'h80);
        rom[8'h80] = ins(6'h01, 8'h02);
        rom[8'h81] = ins(6'h10, 8'hFF);
        rom[8'hFF] = ins(6'h02, 8'h01);
        rom[8'h01] = ins(6'h09, 8'h00);
        fetch_q = '{9'h000, 9'h010, 9'h011, 9'h040, 9'h041, 9'h042, 9'h080, 9'h081,
                    9'h0FF, 9'h000, 9'h001, 9'h002};
        out_q = '{8'h03};
        do_reset();
        run_to_halt(8'h02);

        // JMP located at 0xFF targeting 0x00.
        clear_rom();
        rom[8'h00] = ins(6'h12, 8'h05);
        rom[8'h01] = ins(6'h01, 8'h01);
        rom[8'h02] = ins(6'h10, 8'hFF);
        rom[8'hFF] = ins(6'h10, 8'h00);
        rom[8'h05] = ins(6'h09, 8'h00);
        fetch_q = '{9'h000, 9'h001, 9'h002, 9'h0FF, 9'h000, 9'h005, 9'h006};
        out_q = '{8'h01};
        do_reset();
        run_to_halt(8'h06);

        // Nested CALL/RET, then RET on an empty stack.
        clear_rom();
        for (int i = 0; i < 3; i++) rom[i] = ins(6'h00, 8'h00);
        rom[8'h03] = ins(6'h13, 8'h10);
        rom[8'h10] = ins(6'h13, 8'h20);
        rom[8'h20] = ins(6'h14, 8'h00);
        rom[8'h11] = ins(6'h14, 8'h00);
        rom[8'h04] = ins(6'h14, 8'h00);
        fetch_q = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h010, 9'h020, 9'h011, 9'h004, 9'h105};
        out_q.delete();
        do_reset();
        run_to_halt(8'h05);

        // CALL on a full stack is suppressed and flags the error.
        clear_rom();
        rom[8'h00] = ins(6'h13, 8'h30);
        rom[8'h30] = ins(6'h13, 8'h40);
        rom[8'h40] = ins(6'h13, 8'h50);
        rom[8'h41] = ins(6'h14, 8'h00);
        rom[8'h31] = ins(6'h14, 8'h00);
        rom[8'h50] = ins(6'h09, 8'h00);
        fetch_q = '{9'h000, 9'h030, 9'h040, 9'h141, 9'h131, 9'h101};
        do_reset();
        run_to_halt(8'h01);

        // HALT at 0x07 after a run of NOPs.
        clear_rom();
        for (int i = 0; i < 7; i++) rom[i] = ins(6'h00, 8'h00);
        for (int i = 0; i < 8; i++) push_fetch(8'(i), 1'b0);
        do_reset();
        run_to_halt(8'h07);

        // Reset asserted during an EXEC cycle of a looping program.
        chk_fetch = 1'b0;
        clear_rom();
        rom[8'h00] = ins(6'h14, 8'h00);
        rom[8'h01] = ins(6'h01, 8'h77);
        rom[8'h02] = ins(6'h09, 8'h00);
        rom[8'h03] = ins(6'h10, 8'h03);
        out_q = '{8'h77};
        do_reset();
        mem_en = 1'b1;
        begin
            int n;
            n = 0;
            while (out_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("midop_out_seen", 32'(out_q.size()), 32'd0);
            n = 0;
            @(negedge clk);
            while (bus.inst_req !== 1'b0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("midop_in_exec", 32'(bus.inst_req), 32'd0);
            check("midop_err_before", 32'(bus.stk_err), 32'd1);
        end
        rst    = 1'b1;
        mem_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("midop");
        clear_rom();
        rom[8'h00] = ins(6'h09, 8'h00);
        fetch_q = '{9'h000, 9'h001};
        out_q = '{8'h00};
        chk_fetch = 1'b1;
        rst = 1'b0;
        run_to_halt(8'h01);

        // Carry flag: ADDI overflow, JC, ADCI.
        clear_rom();
        rom[8'h00] = ins(6'h01, 8'hFF);
        rom[8'h01] = ins(6'h02, 8'h01);
        rom[8'h02] = ins(6'h15, 8'h30);
        rom[8'h30] = ins(6'h09, 8'h00);
        rom[8'h31] = ins(6'h0A, 8'h00);
        rom[8'h32] = ins(6'h15, 8'h50);
        rom[8'h33] = ins(6'h09, 8'h00);
        rom[8'h03] = ins(6'h09, 8'h00);
        rom[8'h04] = ins(6'h0A, 8'h00);
        rom[8'h05] = ins(6'h15, 8'h50);
        rom[8'h06] = ins(6'h09, 8'h00);
`ifdef CARBON_CORE_CARRY_EN
        fetch_q = '{9'h000, 9'h001, 9'h002, 9'h030, 9'h031, 9'h032, 9'h033, 9'h034};
        out_q = '{8'h00, 8'h01};
        do_reset();
        run_to_halt(8'h34);
`else
        fetch_q = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007};
        out_q = '{8'h00, 8'h00};
        do_reset();
        run_to_halt(8'h07);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
